// File: rtl/msj_angle_spi_poller_pkg.sv
// Shared types and word-check helper for the angle sensor SPI poller.
package msj_angle_pkg;

    localparam int ANGLE_W    = 14;
    localparam int FRAME_W    = 16;
    localparam int EF_BIT     = 14;
    localparam int PARITY_BIT = 15;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    typedef struct packed {
        logic               parity_ok;
        logic               ef;
        logic [ANGLE_W-1:0] angle;
    } word_chk_t;

    function automatic word_chk_t check_word(logic [FRAME_W-1:0] w);
        word_chk_t c;
        c.parity_ok = ~(^w);
        c.ef        = w[EF_BIT];
        c.angle     = w[ANGLE_W-1:0];
        return c;
    endfunction

endpackage

// File: rtl/msj_angle_spi_poller_if.sv
// Shared SPI bus: one SCK/MOSI/MISO with a select per sensor.
interface msj_angle_spi_poller_if #(
    parameter int N = 8
);
    logic         sck;
    logic         mosi;
    logic         miso;
    logic [N-1:0] ss_n;

    modport master (output sck, output mosi, output ss_n, input miso);
    modport slave  (input sck, input mosi, input ss_n, output miso);
endinterface

// File: rtl/msj_angle_spi_poller_spi_mode1_frame.sv
// One 16-bit SPI mode-1 transfer: SETUP, 32 SCK half-periods, HOLD.
module spi_mode1_frame
    import msj_angle_pkg::*;
#(
    parameter int               N        = 8,
    parameter int               CLK_DIV  = 10,
    parameter logic [FRAME_W-1:0] READ_CMD = 16'hFFFF,
    localparam int              IW       = (N > 1) ? $clog2(N) : 1,
    localparam int              CW       = $clog2(CLK_DIV)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [IW-1:0]      sel,
    output logic               done,
    output logic [FRAME_W-1:0] rx_word,
    output logic               sck,
    output logic               mosi,
    output logic [N-1:0]       ss_n,
    input  logic               miso
);

    state_t             st;
    state_t             st_nx;
    logic [CW-1:0]      cnt;
    logic [4:0]         half;
    logic [FRAME_W-1:0] sh;
    logic               tick;
    logic [3:0]         nb;

    assign tick    = (cnt == CW'(CLK_DIV - 1));
    assign nb      = half[4:1] + 4'd1;
    assign rx_word = sh;

    always_ff @(posedge clock) begin
        if (reset) st <= IDLE;
        else       st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        unique case (st)
            IDLE:    if (start) st_nx = SETUP;
            SETUP:   if (tick) st_nx = SHIFT;
            SHIFT:   if (tick && half == 5'd31) st_nx = HOLD;
            HOLD:    if (tick) st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_comb begin
        sck  = 1'b0;
        done = 1'b0;
        ss_n = '1;
        for (int i = 0; i < N; i++)
            if (st != IDLE && sel == IW'(i)) ss_n[i] = 1'b0;
        if (st == SHIFT) sck = ~half[0];
        if (st == HOLD && tick) done = 1'b1;
    end

    // Rising edges open even half-periods, falling edges open odd ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt  <= '0;
            half <= '0;
            mosi <= 1'b0;
            sh   <= '0;
        end else if (st == IDLE) begin
            cnt  <= '0;
            half <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (st == SETUP && tick)
                mosi <= READ_CMD[FRAME_W-1];
            if (st == SHIFT && tick) begin
                half <= half + 5'd1;
                if (!half[0])
                    sh <= {sh[FRAME_W-2:0], miso};
                else if (half != 5'd31)
                    mosi <= READ_CMD[4'd15 - nb];
            end
        end
    end

endmodule

// File: rtl/msj_angle_spi_poller.sv
// Round-robin poller for AS5047-style angle sensors on a shared SPI bus,
// with per-sensor angle bank, valid, parity and error flags.
module msj_angle_spi_poller
    import msj_angle_pkg::*;
#(
    parameter int                 NUM_SENSORS = 8,
    parameter int                 CLK_DIV     = 10,
    parameter int                 GAP_CYCLES  = 20,
    parameter logic [FRAME_W-1:0] READ_CMD    = 16'hFFFF,
    localparam int                IW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1,
    localparam int                GW = $clog2(GAP_CYCLES + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_SENSORS-1:0]         sensor_mask,
    msj_angle_spi_poller_if.master         spi,
    output logic [NUM_SENSORS*ANGLE_W-1:0] angle_flat,
    output logic [NUM_SENSORS-1:0]         angle_valid,
    output logic [NUM_SENSORS-1:0]         parity_err,
    output logic [NUM_SENSORS-1:0]         sensor_err,
    output logic                           frame_done,
    output logic [IW-1:0]                  frame_idx
);

    state_t               st;
    state_t               st_nx;
    logic [GW-1:0]        gap_cnt;
    logic [IW-1:0]        cur;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        pick;
    logic [NUM_SENSORS-1:0] first;
    logic                 go;
    logic                 last_gap;
    logic                 start;
    logic                 f_done;
    logic [FRAME_W-1:0]   rx_word;
    word_chk_t            chk;

    spi_mode1_frame #(
        .N        (NUM_SENSORS),
        .CLK_DIV  (CLK_DIV),
        .READ_CMD (READ_CMD)
    ) u_frame (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .sel     (cur),
        .done    (f_done),
        .rx_word (rx_word),
        .sck     (spi.sck),
        .mosi    (spi.mosi),
        .ss_n    (spi.ss_n),
        .miso    (spi.miso)
    );

    assign go       = enable && (|sensor_mask);
    assign last_gap = (gap_cnt == GW'(GAP_CYCLES - 1));

    // First set mask bit at or after ptr, wrapping around.
    always_comb begin
        int j;
        pick = ptr;
        for (int k = NUM_SENSORS - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_SENSORS;
            if (sensor_mask[j]) pick = IW'(j);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) st <= IDLE;
        else       st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        unique case (st)
            IDLE:    if (go) st_nx = SHIFT;
            SHIFT:   if (f_done) st_nx = GAP;
            GAP:     if (last_gap) st_nx = go ? SHIFT : IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_comb begin
        start = 1'b0;
        if (st == IDLE || (st == GAP && last_gap))
            start = go;
    end

    always_comb chk = check_word(rx_word);

    always_ff @(posedge clock) begin
        if (reset) begin
            gap_cnt     <= '0;
            cur         <= '0;
            ptr         <= '0;
            first       <= '1;
            angle_flat  <= '0;
            angle_valid <= '0;
            parity_err  <= '0;
            sensor_err  <= '0;
            frame_done  <= 1'b0;
            frame_idx   <= '0;
        end else begin
            frame_done <= f_done;
            gap_cnt    <= (st == GAP) ? gap_cnt + 1'b1 : '0;
            if (start) cur <= pick;
            if (f_done) begin
                frame_idx <= cur;
                ptr <= (cur == IW'(NUM_SENSORS - 1)) ? '0 : cur + 1'b1;
                // Sensor answers the previous command: first reply is stale.
                if (first[cur]) begin
                    first[cur] <= 1'b0;
                end else if (!chk.parity_ok) begin
                    parity_err[cur] <= 1'b1;
                end else if (chk.ef) begin
                    sensor_err[cur]  <= 1'b1;
                    angle_valid[cur] <= 1'b0;
                end else begin
                    angle_flat[int'(cur)*ANGLE_W +: ANGLE_W] <= chk.angle;
                    angle_valid[cur] <= 1'b1;
                    parity_err[cur]  <= 1'b0;
                    sensor_err[cur]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_msj_angle_spi_poller.sv
// Bench for msj_angle_spi_poller: SPI sensor models, table vectors,
// random frames against a per-sensor reference model.
module tb_msj_angle_spi_poller;

    localparam int          N      = 8;
    localparam int          CD     = 2;
    localparam int          GAP    = 4;
    localparam logic [15:0] CMD    = 16'hA5C3;
    localparam int          PERIOD = CD * 34 + GAP;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [N-1:0]     mask = '0;
    logic [N*14-1:0]  angle_flat;
    logic [N-1:0]     angle_valid;
    logic [N-1:0]     parity_err;
    logic [N-1:0]     sensor_err;
    logic             frame_done;
    logic [2:0]       frame_idx;

    msj_angle_spi_poller_if #(.N(N)) spi ();

    msj_angle_spi_poller #(
        .NUM_SENSORS (N),
        .CLK_DIV     (CD),
        .GAP_CYCLES  (GAP),
        .READ_CMD    (CMD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .sensor_mask (mask),
        .spi         (spi),
        .angle_flat  (angle_flat),
        .angle_valid (angle_valid),
        .parity_err  (parity_err),
        .sensor_err  (sensor_err),
        .frame_done  (frame_done),
        .frame_idx   (frame_idx)
    );

    always #5 clock = ~clock;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int multi_low = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock)
        if (!reset && $countones(~spi.ss_n) > 1) multi_low++;

    // Sensor side: latch the reply word when selected, shift on SCK rise.
    logic [15:0] resp [N];
    logic [15:0] cur_word = '0;
    logic [15:0] mosi_sh = '0;
    int          bitn = 0;
    int          falls = 0;

    always @(spi.ss_n)
        if (spi.ss_n != '1) begin
            bitn  = 0;
            falls = 0;
            for (int i = 0; i < N; i++)
                if (!spi.ss_n[i]) cur_word = resp[i];
        end

    always @(posedge spi.sck) begin
        if (bitn < 16) spi.miso = cur_word[15 - bitn];
        bitn++;
    end

    always @(negedge spi.sck) begin
        falls++;
        mosi_sh = {mosi_sh[14:0], spi.mosi};
    end

    // Reference model, per sensor.
    logic [13:0] m_slot [N];
    bit          m_valid [N];
    bit          m_perr [N];
    bit          m_serr [N];
    bit          m_first [N];
    int          m_ptr;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_slot[i]  = '0;
            m_valid[i] = 0;
            m_perr[i]  = 0;
            m_serr[i]  = 0;
            m_first[i] = 1;
        end
        m_ptr = 0;
    endtask

    function automatic int model_next(logic [N-1:0] m);
        for (int k = 0; k < N; k++)
            if (m[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_frame(int idx, logic [15:0] w);
        if (m_first[idx]) begin
            m_first[idx] = 0;
        end else if ($countones(w) % 2 != 0) begin
            m_perr[idx] = 1;
        end else if (w[14]) begin
            m_serr[idx]  = 1;
            m_valid[idx] = 0;
        end else begin
            m_slot[idx]  = w[13:0];
            m_valid[idx] = 1;
            m_perr[idx]  = 0;
            m_serr[idx]  = 0;
        end
        m_ptr = (idx + 1) % N;
    endtask

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bank(string tag);
        logic [N*14-1:0] ef;
        logic [N-1:0]    ev, ep, es;
        for (int i = 0; i < N; i++) begin
            ef[i*14 +: 14] = m_slot[i];
            ev[i] = m_valid[i];
            ep[i] = m_perr[i];
            es[i] = m_serr[i];
        end
        check({tag, " angle_flat"}, angle_flat, ef);
        check({tag, " angle_valid"}, angle_valid, ev);
        check({tag, " parity_err"}, parity_err, ep);
        check({tag, " sensor_err"}, sensor_err, es);
    endtask

    task automatic wait_done(string tag, output bit ok);
        ok = 0;
        for (int i = 0; i < 3 * PERIOD + 50; i++) begin
            @(negedge clock);
            if (frame_done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            nvec++;
            nerr++;
            $display("FAIL %s frame_done: got timeout expected pulse", tag);
        end
    endtask

    task automatic wait_sck_high(string tag);
        bit seen = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clock);
            if (spi.sck) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            nvec++;
            nerr++;
            $display("FAIL %s sck: got no SHIFT expected sck high", tag);
        end
    endtask

    task automatic do_frame(string tag);
        bit ok;
        int e = model_next(mask);
        wait_done(tag, ok);
        if (ok) begin
            check({tag, " frame_idx"}, frame_idx, e);
            check({tag, " mosi word"}, mosi_sh, CMD);
            model_frame(e, cur_word);
            check_bank(tag);
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w = 16'($urandom);
        case ($urandom_range(0, 3))
            0: ;
            1: begin w[14] = 1'b1; w[15] = ^w[14:0]; end
            default: begin w[14] = 1'b0; w[15] = ^w[14:0]; end
        endcase
        return w;
    endfunction

    task automatic randomize_resp();
        for (int i = 0; i < N; i++) resp[i] = rand_word();
    endtask

    typedef struct {
        logic [15:0] word;
        logic [13:0] slot;
        logic        valid;
        logic        perr;
        logic        serr;
        int          period;
    } vec_t;

    vec_t tbl [5];

    initial begin
        bit ok;
        int t_last;
        int viol;

        tbl[0] = '{16'h9234, 14'h0000, 1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{16'h9234, 14'h1234, 1'b1, 1'b0, 1'b0, PERIOD};
        tbl[2] = '{16'h1234, 14'h1234, 1'b1, 1'b1, 1'b0, PERIOD};
        tbl[3] = '{16'h4001, 14'h1234, 1'b0, 1'b1, 1'b1, PERIOD};
        tbl[4] = '{16'h9234, 14'h1234, 1'b1, 1'b0, 1'b0, PERIOD};

        spi.miso = 1'b0;
        for (int i = 0; i < N; i++) resp[i] = '0;
        model_reset();

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst sck", spi.sck, 1'b0);
        check("rst mosi", spi.mosi, 1'b0);
        check("rst ss_n", spi.ss_n, 8'hFF);
        check("rst angle_flat", angle_flat, '0);
        check("rst angle_valid", angle_valid, '0);
        check("rst parity_err", parity_err, '0);
        check("rst sensor_err", sensor_err, '0);
        check("rst frame_done", frame_done, 1'b0);
        check("rst frame_idx", frame_idx, 3'd0);

        reset  = 1'b0;
        mask   = 8'h01;
        t_last = cyc;
        for (int i = 0; i < 5; i++) begin
            resp[0] = tbl[i].word;
            if (i == 0) enable = 1'b1;
            wait_done($sformatf("tbl%0d", i), ok);
            if (!ok) continue;
            check($sformatf("tbl%0d idx", i), frame_idx, 3'd0);
            check($sformatf("tbl%0d slot0", i), angle_flat[13:0], tbl[i].slot);
            check($sformatf("tbl%0d valid0", i), angle_valid[0], tbl[i].valid);
            check($sformatf("tbl%0d perr0", i), parity_err[0], tbl[i].perr);
            check($sformatf("tbl%0d serr0", i), sensor_err[0], tbl[i].serr);
            check($sformatf("tbl%0d falls", i), falls, 16);
            check($sformatf("tbl%0d mosi", i), mosi_sh, CMD);
            if (tbl[i].period != 0)
                check($sformatf("tbl%0d period", i), cyc - t_last, tbl[i].period);
            t_last = cyc;
            model_frame(0, cur_word);
        end

        mask = 8'hA5;
        for (int f = 0; f < 20; f++) begin
            randomize_resp();
            do_frame($sformatf("rnd%0d", f));
        end
        check("one select low", multi_low, 0);

        wait_sck_high("drop");
        enable = 1'b0;
        randomize_resp();
        do_frame("drop");
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (spi.ss_n != '1 || spi.sck || frame_done) viol++;
        end
        check("idle quiet", viol, 0);
        enable = 1'b1;
        randomize_resp();
        do_frame("resume");

        wait_sck_high("rstmid");
        reset = 1'b1;
        @(negedge clock);
        check("rstmid ss_n", spi.ss_n, 8'hFF);
        check("rstmid sck", spi.sck, 1'b0);
        check("rstmid angle_flat", angle_flat, '0);
        check("rstmid angle_valid", angle_valid, '0);
        check("rstmid parity_err", parity_err, '0);
        check("rstmid sensor_err", sensor_err, '0);
        reset = 1'b0;
        model_reset();
        for (int f = 0; f < 10; f++) begin
            randomize_resp();
            do_frame($sformatf("post%0d", f));
        end
        check("one select low end", multi_low, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
